// File: rtl/gemac_csr_pkg.sv
// Shared constants for the GEMAC Wishbone CSR block: word indices, field bit positions, reset defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gemac_csr_pkg;

    // Word indices (byte address >> 2)
    localparam int W_SETTINGS     = 0;
    localparam int W_UCAST_H      = 1;
    localparam int W_UCAST_L      = 2;
    localparam int W_MIIMODER     = 3;
    localparam int W_MIIADDR      = 4;
    localparam int W_MIIDATA      = 5;
    localparam int W_MIICMD       = 6;
    localparam int W_MIISTATUS    = 7;
    localparam int W_MIIRX        = 8;
    localparam int W_PAUSE_TIME   = 9;
    localparam int W_PAUSE_THRESH = 10;
    localparam int W_IRQ_MASK     = 11;
    localparam int W_MCAST_BASE   = 16;

    // SETTINGS bit positions
    localparam int SET_PAUSE_RESPECT_EN = 0;
    localparam int SET_PASS_ALL         = 1;
    localparam int SET_PASS_PAUSE       = 2;
    localparam int SET_PASS_BCAST       = 3;
    localparam int SET_PASS_MCAST       = 4;
    localparam int SET_PASS_UCAST       = 5;
    localparam int SET_PAUSE_REQ_EN     = 6;

    // MIICMD bit positions
    localparam int CMD_SCAN  = 0;
    localparam int CMD_RSTAT = 1;
    localparam int CMD_WCTRL = 2;

    // MIISTATUS bit positions
    localparam int STAT_LINKFAIL = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_NVALID   = 2;
    localparam int STAT_DONE     = 3;

    // Reset defaults
    localparam logic [6:0]  SET_DEFAULT_C = 7'b0111101;
    localparam logic [47:0] UCAST_DEF_C   = 48'h0037_ffff3737;

endpackage

// File: rtl/gemac_wb_csr_if.sv
// Wishbone classic slave bus bundle for the GEMAC CSR block.
// Latency: n/a (wires only).
// Backpressure: n/a; the slave paces the master with one ack/err pulse per access.
// Signals: wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_dat_i from master; wb_dat_o/wb_ack/wb_err from slave.
interface gemac_wb_csr_if #(
    parameter int AW = 8
);
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack;
    logic          wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        output wb_dat_o, wb_ack, wb_err
    );
endinterface

// File: rtl/gemac_csr_bytereg.sv
// Generic RW register with per-byte-lane write enables and a parameterised reset value.
// Latency: written value visible on q the cycle after we.
// Backpressure: none; a write is always taken when we is high.
// Ports: clk, rst (sync, high), we, be[NB-1:0] (lane enables, bit i in lane i/8), din[W-1:0], q[W-1:0].
module gemac_csr_bytereg #(
    parameter int          W   = 8,
    parameter logic [W-1:0] DEF = '0,
    parameter int          NB  = (W + 7) / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [NB-1:0] be,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  q
);
    logic [W-1:0] bitmask;

    always_comb begin
        bitmask = '0;
        for (int i = 0; i < W; i++) begin
            bitmask[i] = be[i / 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= DEF;
        end else if (we) begin
            q <= (q & ~bitmask) | (din & bitmask);
        end
    end
endmodule

// File: rtl/gemac_wb_csr.sv
// GEMAC Wishbone CSR block: filter settings, unicast/multicast addresses, pause config, MIIM register set.
// Latency: ack/err and read data registered, one cycle after the access cycle.
// Backpressure: no new access is taken while ack/err is high, so a held strobe is answered every 2nd cycle.
// Ports: clk, rst (sync, high); wb (Wishbone slave modport); config outputs settings/ucast_addr/mcast_addr/
//   pause_*/miim_*; MIIM engine handshake inputs miim_*_start, miim_update_rx, miim_prsd, status bits; irq.
// Optional: define GEMAC_WB_IRQ_EN for the MIIM-done sticky flag, IRQ_MASK word and irq output.
module gemac_wb_csr
    import gemac_csr_pkg::*;
#(
    parameter int          AW          = 8,
    parameter int          NUM_MCAST   = 4,
    parameter logic [6:0]  SET_DEFAULT = SET_DEFAULT_C,
    parameter logic [47:0] UCAST_DEF   = UCAST_DEF_C
) (
    input  logic                    clk,
    input  logic                    rst,
    gemac_wb_csr_if.slave           wb,
    output logic [6:0]              settings,
    output logic [47:0]             ucast_addr,
    output logic [48*NUM_MCAST-1:0] mcast_addr,
    output logic [15:0]             pause_time,
    output logic [15:0]             pause_thresh,
    output logic [7:0]              miim_divider,
    output logic                    miim_nopre,
    output logic [4:0]              miim_rgad,
    output logic [4:0]              miim_fiad,
    output logic [15:0]             miim_ctrl_data,
    output logic                    miim_wctrl,
    output logic                    miim_rstat,
    output logic                    miim_scan,
    input  logic                    miim_wctrl_start,
    input  logic                    miim_rstat_start,
    input  logic                    miim_update_rx,
    input  logic [15:0]             miim_prsd,
    input  logic                    miim_busy,
    input  logic                    miim_nvalid,
    input  logic                    miim_linkfail,
    output logic                    irq
);
    logic [31:0] widx;
    logic        acc, wr, mapped;
    logic        ack_q, err_q;
    logic [31:0] rdata, dat_q;
    logic [3:0]  sel;
    logic [31:0] din;
    logic [15:0] ucast_h;
    logic [31:0] ucast_l;
    logic [8:0]  moder;
    logic [2:0]  cmd;
    logic        cmd_wr;
    logic [15:0] rx_q;
    logic        done;
    logic [15:0] mc_h [NUM_MCAST];
    logic [31:0] mc_l [NUM_MCAST];
    logic        unused_adr;

    assign widx       = 32'(wb.wb_adr[AW-1:2]);
    assign unused_adr = ^wb.wb_adr[1:0];
    assign sel        = wb.wb_sel;
    assign din        = wb.wb_dat_i;

    // A pending response blocks the next access, giving exactly one pulse per access.
    assign acc = wb.wb_cyc & wb.wb_stb & ~ack_q & ~err_q;
    assign wr  = acc & wb.wb_we & mapped;

    gemac_csr_bytereg #(.W(7), .DEF(SET_DEFAULT)) u_settings (
        .clk, .rst, .we(wr & (widx == 32'(W_SETTINGS))), .be(sel[0:0]), .din(din[6:0]), .q(settings));
    gemac_csr_bytereg #(.W(16), .DEF(UCAST_DEF[47:32])) u_ucast_h (
        .clk, .rst, .we(wr & (widx == 32'(W_UCAST_H))), .be(sel[1:0]), .din(din[15:0]), .q(ucast_h));
    gemac_csr_bytereg #(.W(32), .DEF(UCAST_DEF[31:0])) u_ucast_l (
        .clk, .rst, .we(wr & (widx == 32'(W_UCAST_L))), .be(sel), .din(din), .q(ucast_l));
    gemac_csr_bytereg #(.W(9)) u_moder (
        .clk, .rst, .we(wr & (widx == 32'(W_MIIMODER))), .be(sel[1:0]), .din(din[8:0]), .q(moder));
    // MIIADDR fields sit in different byte lanes with a gap, so they are held separately.
    gemac_csr_bytereg #(.W(5)) u_fiad (
        .clk, .rst, .we(wr & (widx == 32'(W_MIIADDR))), .be(sel[0:0]), .din(din[4:0]), .q(miim_fiad));
    gemac_csr_bytereg #(.W(5)) u_rgad (
        .clk, .rst, .we(wr & (widx == 32'(W_MIIADDR))), .be(sel[1:1]), .din(din[12:8]), .q(miim_rgad));
    gemac_csr_bytereg #(.W(16)) u_miidata (
        .clk, .rst, .we(wr & (widx == 32'(W_MIIDATA))), .be(sel[1:0]), .din(din[15:0]), .q(miim_ctrl_data));
    gemac_csr_bytereg #(.W(16)) u_pause_time (
        .clk, .rst, .we(wr & (widx == 32'(W_PAUSE_TIME))), .be(sel[1:0]), .din(din[15:0]), .q(pause_time));
    gemac_csr_bytereg #(.W(16)) u_pause_thresh (
        .clk, .rst, .we(wr & (widx == 32'(W_PAUSE_THRESH))), .be(sel[1:0]), .din(din[15:0]), .q(pause_thresh));

    for (genvar k = 0; k < NUM_MCAST; k++) begin : g_mcast
        gemac_csr_bytereg #(.W(16)) u_h (
            .clk, .rst, .we(wr & (widx == 32'(W_MCAST_BASE + 2*k))), .be(sel[1:0]), .din(din[15:0]), .q(mc_h[k]));
        gemac_csr_bytereg #(.W(32)) u_l (
            .clk, .rst, .we(wr & (widx == 32'(W_MCAST_BASE + 2*k + 1))), .be(sel), .din(din), .q(mc_l[k]));
        assign mcast_addr[48*k +: 48] = {mc_h[k], mc_l[k]};
    end

    assign ucast_addr   = {ucast_h, ucast_l};
    assign miim_divider = moder[7:0];
    assign miim_nopre   = moder[8];

    // MIICMD: a busy engine or missing lane 0 discards the write; a write beats a same-cycle start strobe.
    assign cmd_wr = wr & (widx == 32'(W_MIICMD)) & ~miim_busy & sel[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd <= '0;
        end else if (cmd_wr) begin
            cmd <= din[2:0];
        end else begin
            if (miim_wctrl_start) cmd[CMD_WCTRL] <= 1'b0;
            if (miim_rstat_start) cmd[CMD_RSTAT] <= 1'b0;
        end
    end

    assign miim_wctrl = cmd[CMD_WCTRL];
    assign miim_rstat = cmd[CMD_RSTAT];
    assign miim_scan  = cmd[CMD_SCAN];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= '0;
        end else if (miim_update_rx) begin
            rx_q <= miim_prsd;
        end
    end

`ifdef GEMAC_WB_IRQ_EN
    logic busy_q, irq_mask, irq_q, w1c;

    gemac_csr_bytereg #(.W(1)) u_irq_mask (
        .clk, .rst, .we(wr & (widx == 32'(W_IRQ_MASK))), .be(sel[0:0]), .din(din[0:0]), .q(irq_mask));

    assign w1c = wr & (widx == 32'(W_MIISTATUS)) & sel[0] & din[STAT_DONE];

    // Done is sticky on the busy falling edge; a fresh completion beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            busy_q <= miim_busy;
            if (busy_q & ~miim_busy) begin
                done <= 1'b1;
            end else if (w1c) begin
                done <= 1'b0;
            end
            irq_q <= done & irq_mask;
        end
    end

    assign irq = irq_q;
`else
    assign done = 1'b0;
    assign irq  = 1'b0;
`endif

    always_comb begin
        rdata  = '0;
        mapped = 1'b0;
        case (widx)
            32'(W_SETTINGS):     begin mapped = 1'b1; rdata[6:0]  = settings;       end
            32'(W_UCAST_H):      begin mapped = 1'b1; rdata[15:0] = ucast_h;        end
            32'(W_UCAST_L):      begin mapped = 1'b1; rdata       = ucast_l;        end
            32'(W_MIIMODER):     begin mapped = 1'b1; rdata[8:0]  = moder;          end
            32'(W_MIIADDR):      begin mapped = 1'b1; rdata[12:8] = miim_rgad; rdata[4:0] = miim_fiad; end
            32'(W_MIIDATA):      begin mapped = 1'b1; rdata[15:0] = miim_ctrl_data; end
            32'(W_MIICMD):       begin mapped = 1'b1; rdata[2:0]  = cmd;            end
            32'(W_MIISTATUS):    begin
                mapped = 1'b1;
                rdata[STAT_DONE]     = done;
                rdata[STAT_NVALID]   = miim_nvalid;
                rdata[STAT_BUSY]     = miim_busy;
                rdata[STAT_LINKFAIL] = miim_linkfail;
            end
            32'(W_MIIRX):        begin mapped = 1'b1; rdata[15:0] = rx_q;           end
            32'(W_PAUSE_TIME):   begin mapped = 1'b1; rdata[15:0] = pause_time;     end
            32'(W_PAUSE_THRESH): begin mapped = 1'b1; rdata[15:0] = pause_thresh;   end
`ifdef GEMAC_WB_IRQ_EN
            32'(W_IRQ_MASK):     begin mapped = 1'b1; rdata[0]    = irq_mask;       end
`endif
            default: ;
        endcase
        for (int k = 0; k < NUM_MCAST; k++) begin
            if (widx == 32'(W_MCAST_BASE + 2*k)) begin
                mapped      = 1'b1;
                rdata[15:0] = mc_h[k];
            end
            if (widx == 32'(W_MCAST_BASE + 2*k + 1)) begin
                mapped = 1'b1;
                rdata  = mc_l[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc & mapped;
            err_q <= acc & ~mapped;
            if (acc) dat_q <= rdata;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_err   = err_q;
    assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_gemac_wb_csr.sv
// Self-checking bench for gemac_wb_csr: directed register/MIIM/IRQ scenarios then random bus traffic,
// all compared against a word-array reference model built from the register map rules.
// Honors GEMAC_WB_IRQ_EN the same way as the design.
module tb_gemac_wb_csr;
    localparam int AW = 8;
    localparam int NM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gemac_wb_csr_if #(.AW(AW)) wb ();

    logic [6:0]       settings;
    logic [47:0]      ucast_addr;
    logic [48*NM-1:0] mcast_addr;
    logic [15:0]      pause_time, pause_thresh;
    logic [7:0]       miim_divider;
    logic             miim_nopre;
    logic [4:0]       miim_rgad, miim_fiad;
    logic [15:0]      miim_ctrl_data;
    logic             miim_wctrl, miim_rstat, miim_scan;
    logic             miim_wctrl_start = 1'b0, miim_rstat_start = 1'b0, miim_update_rx = 1'b0;
    logic [15:0]      miim_prsd = '0;
    logic             miim_busy = 1'b0, miim_nvalid = 1'b0, miim_linkfail = 1'b0;
    logic             irq;

    gemac_wb_csr #(.AW(AW), .NUM_MCAST(NM)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .settings(settings), .ucast_addr(ucast_addr), .mcast_addr(mcast_addr),
        .pause_time(pause_time), .pause_thresh(pause_thresh),
        .miim_divider(miim_divider), .miim_nopre(miim_nopre), .miim_rgad(miim_rgad), .miim_fiad(miim_fiad),
        .miim_ctrl_data(miim_ctrl_data), .miim_wctrl(miim_wctrl), .miim_rstat(miim_rstat), .miim_scan(miim_scan),
        .miim_wctrl_start(miim_wctrl_start), .miim_rstat_start(miim_rstat_start),
        .miim_update_rx(miim_update_rx), .miim_prsd(miim_prsd),
        .miim_busy(miim_busy), .miim_nvalid(miim_nvalid), .miim_linkfail(miim_linkfail),
        .irq(irq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one 32-bit image per word index, plus MIIRX and the done flag.
    logic [31:0] mem [64];
    logic [15:0] m_rx;
    logic        m_done;
    logic        drop_busy_on_acc = 1'b0;
    logic        wstart_on_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mapped(int w);
        if (w <= 10) return 1'b1;
`ifdef GEMAC_WB_IRQ_EN
        if (w == 11) return 1'b1;
`endif
        if (w >= 16 && w < 16 + 2*NM) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rw_mask(int w);
        case (w)
            0:      return 32'h0000_007F;
            1:      return 32'h0000_FFFF;
            2:      return 32'hFFFF_FFFF;
            3:      return 32'h0000_01FF;
            4:      return 32'h0000_1F1F;
            5:      return 32'h0000_FFFF;
            6:      return 32'h0000_0007;
            9, 10:  return 32'h0000_FFFF;
            11:     return 32'h0000_0001;
            default: ;
        endcase
        if (w >= 16 && w < 16 + 2*NM) return (w % 2 == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_read(int w);
        if (!is_mapped(w)) return 32'h0;
        if (w == 7) return {28'h0, m_done, miim_nvalid, miim_busy, miim_linkfail};
        if (w == 8) return {16'h0, m_rx};
        return mem[w];
    endfunction

    function automatic void model_write(int w, logic [3:0] sel, logic [31:0] d, logic busy_now);
        logic [31:0] lm;
        if (!is_mapped(w)) return;
`ifdef GEMAC_WB_IRQ_EN
        if (w == 7 && sel[0] && d[3]) m_done = 1'b0;
        if (drop_busy_on_acc && busy_now) m_done = 1'b1;
`endif
        if (w == 6 && (busy_now || !sel[0])) return;
        lm = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}} & rw_mask(w);
        mem[w] = (mem[w] & ~lm) | (d & lm);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_003D;
        mem[1] = 32'h0000_0037;
        mem[2] = 32'hFFFF_3737;
        m_rx   = 16'h0;
        m_done = 1'b0;
    endtask

    task automatic wb_acc(input bit we, input int w, input logic [3:0] sel, input logic [31:0] d,
                          output logic [31:0] rd, output logic a, output logic e);
        @(posedge clk); #1;
        wb.wb_cyc   = 1'b1;
        wb.wb_stb   = 1'b1;
        wb.wb_we    = we;
        wb.wb_adr   = AW'(w * 4);
        wb.wb_sel   = sel;
        wb.wb_dat_i = d;
        if (wstart_on_acc)    miim_wctrl_start = 1'b1;
        if (drop_busy_on_acc) miim_busy = 1'b0;
        @(posedge clk); #1;
        wb.wb_cyc = 1'b0;
        wb.wb_stb = 1'b0;
        wb.wb_we  = 1'b0;
        miim_wctrl_start = 1'b0;
        rd = wb.wb_dat_o;
        a  = wb.wb_ack;
        e  = wb.wb_err;
    endtask

    task automatic do_read(input string tag, input int w);
        logic [31:0] rd, exp;
        logic a, e;
        exp = model_read(w);
        wb_acc(1'b0, w, 4'hF, 32'h0, rd, a, e);
        chk({tag, "_ack"}, 64'(a), 64'(is_mapped(w)));
        chk({tag, "_err"}, 64'(e), 64'(!is_mapped(w)));
        chk({tag, "_dat"}, 64'(rd), 64'(exp));
    endtask

    task automatic do_write(input string tag, input int w, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] rd;
        logic a, e, b;
        b = miim_busy;
        wb_acc(1'b1, w, sel, d, rd, a, e);
        chk({tag, "_ack"}, 64'(a), 64'(is_mapped(w)));
        chk({tag, "_err"}, 64'(e), 64'(!is_mapped(w)));
        model_write(w, sel, d, b);
    endtask

    task automatic set_busy(input logic v);
`ifdef GEMAC_WB_IRQ_EN
        if (miim_busy && !v) m_done = 1'b1;
`endif
        miim_busy = v;
        @(posedge clk); #1;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_irq;
        @(posedge clk); #1;
`ifdef GEMAC_WB_IRQ_EN
        exp_irq = m_done & mem[11][0];
`else
        exp_irq = 1'b0;
`endif
        chk({tag, "_settings"}, 64'(settings), 64'(mem[0][6:0]));
        chk({tag, "_ucast"}, 64'(ucast_addr), 64'({mem[1][15:0], mem[2]}));
        for (int k = 0; k < NM; k++)
            chk($sformatf("%s_mcast%0d", tag, k), 64'(mcast_addr[48*k +: 48]),
                64'({mem[16+2*k][15:0], mem[17+2*k]}));
        chk({tag, "_pause"}, 64'({pause_time, pause_thresh}), 64'({mem[9][15:0], mem[10][15:0]}));
        chk({tag, "_moder"}, 64'({miim_nopre, miim_divider}), 64'(mem[3][8:0]));
        chk({tag, "_addr"}, 64'({miim_rgad, miim_fiad}), 64'({mem[4][12:8], mem[4][4:0]}));
        chk({tag, "_mdata"}, 64'(miim_ctrl_data), 64'(mem[5][15:0]));
        chk({tag, "_cmd"}, 64'({miim_wctrl, miim_rstat, miim_scan}), 64'(mem[6][2:0]));
        chk({tag, "_irq"}, 64'(irq), 64'(exp_irq));
    endtask

    initial begin
        logic [3:0]  rsel;
        logic [31:0] rdat;
        int          rw;

        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
        wb.wb_adr = '0;   wb.wb_sel = '0;   wb.wb_dat_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ack", 64'(wb.wb_ack), 64'(0));
        chk("rst_err", 64'(wb.wb_err), 64'(0));
        chk("rst_dat", 64'(wb.wb_dat_o), 64'(0));
        chk("rst_settings", 64'(settings), 64'(7'h3D));
        chk("rst_ucast", 64'(ucast_addr), 64'(48'h0037_FFFF_3737));
        check_outputs("rst");

        do_read("rd0", 0);
        do_read("rd1", 1);
        do_read("rd2", 2);

        // Byte-lane write to UCAST_L: lanes 0 and 2 only
        do_write("ul_sel", 2, 4'b0101, 32'hAABB_CCDD);
        do_read("ul_sel_rd", 2);
        chk("ucast_lanes", 64'(ucast_addr[31:0]), 64'(32'hFFBB_37DD));

        // MIICMD: set wctrl, engine accepts
        do_write("cmd_w4", 6, 4'hF, 32'h4);
        chk("wctrl_set", 64'(miim_wctrl), 64'(1));
        @(posedge clk); #1 miim_wctrl_start = 1'b1;
        @(posedge clk); #1 miim_wctrl_start = 1'b0;
        mem[6][2] = 1'b0;
        chk("wctrl_clr", 64'(miim_wctrl), 64'(0));

        // Busy engine discards command writes
        set_busy(1'b1);
        do_write("cmd_busy", 6, 4'hF, 32'h2);
        do_read("cmd_busy_rd", 6);
        set_busy(1'b0);

        // Write beats a same-cycle start strobe; starts clear only their own bit
        do_write("cmd_w3", 6, 4'hF, 32'h3);
        wstart_on_acc = 1'b1;
        do_write("cmd_race", 6, 4'hF, 32'h7);
        wstart_on_acc = 1'b0;
        chk("cmd_race_val", 64'({miim_wctrl, miim_rstat, miim_scan}), 64'(3'b111));
        @(posedge clk); #1 miim_wctrl_start = 1'b1; miim_rstat_start = 1'b1;
        @(posedge clk); #1 miim_wctrl_start = 1'b0; miim_rstat_start = 1'b0;
        mem[6] = mem[6] & 32'h1;
        do_read("cmd_scan_kept", 6);

        // Multicast slot 1 low half
        do_write("mc1l", 19, 4'hF, 32'h1234_5678);
        chk("mc1_lo", 64'(mcast_addr[79:48]), 64'(32'h1234_5678));
        chk("mc1_hi", 64'(mcast_addr[95:80]), 64'(0));
        chk("mc0", 64'(mcast_addr[47:0]), 64'(0));
        chk("mc2", 64'(mcast_addr[143:96]), 64'(0));
        chk("mc3", 64'(mcast_addr[191:144]), 64'(0));

        // Unmapped words
        do_read("unmap12", 12);
        do_read("unmap40", 40);
        do_read("unmap11", 11);
        do_write("unmap_w", 30, 4'hF, 32'hDEAD_BEEF);

        // Held strobe: a response every second cycle
        @(posedge clk); #1;
        wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b0; wb.wb_adr = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ack%0d", i), 64'(wb.wb_ack), 64'(i % 2 == 0));
            chk($sformatf("b2b_err%0d", i), 64'(wb.wb_err), 64'(0));
            if (i % 2 == 0) chk($sformatf("b2b_dat%0d", i), 64'(wb.wb_dat_o), 64'(mem[0]));
        end
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        @(posedge clk); #1;

        // MIIRX capture and live status bits
        miim_prsd = 16'($urandom);
        miim_update_rx = 1'b1;
        @(posedge clk); #1 miim_update_rx = 1'b0;
        m_rx = miim_prsd;
        miim_prsd = ~miim_prsd;
        do_read("miirx", 8);
        miim_nvalid = 1'b1; miim_linkfail = 1'b1;
        do_read("status", 7);
        do_write("status_ro", 7, 4'hF, 32'h7);
        miim_nvalid = 1'b0; miim_linkfail = 1'b0;
        do_read("status2", 7);
        check_outputs("dir");

        // Reset in the middle of an access drops it
        @(posedge clk); #1;
        wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_adr = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", 64'(wb.wb_ack), 64'(0));
        chk("rst_mid_err", 64'(wb.wb_err), 64'(0));
        wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
        rst = 1'b0;
        model_reset();
        check_outputs("rst2");

`ifdef GEMAC_WB_IRQ_EN
        do_write("irq_mask", 11, 4'hF, 32'h1);
        set_busy(1'b1);
        set_busy(1'b0);
        check_outputs("irq_set");
        chk("irq_on", 64'(irq), 64'(1));
        do_read("irq_stat", 7);
        set_busy(1'b1);
        drop_busy_on_acc = 1'b1;
        do_write("w1c_race", 7, 4'hF, 32'h8);
        drop_busy_on_acc = 1'b0;
        check_outputs("irq_race");
        chk("irq_race_on", 64'(irq), 64'(1));
        do_write("w1c", 7, 4'hF, 32'h8);
        check_outputs("irq_clr");
        chk("irq_off", 64'(irq), 64'(0));
`endif

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            rw   = int'($urandom_range(0, 63));
            rsel = 4'($urandom);
            rdat = $urandom;
            if ($urandom_range(0, 1) == 1) do_write($sformatf("rw%0d", n), rw, rsel, rdat);
            else                           do_read($sformatf("rr%0d", n), rw);
        end
        check_outputs("final");
        for (int w = 0; w < 64; w++) do_read($sformatf("sweep%0d", w), w);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
